truth_table_sweeper: RTL

- Sequential stimulus/capture stage wrapped around the team's 4-input logic stage.
- That stage takes inputs A, B, C, D and produces F1 = (~B&C) | A | ((~A&B) ^ D) and F2 = D | (~A&B).
- On a start request this block drives all 16 input combinations in order, waits a programmable settle time on each, and samples the returned F1/F2.
- It assembles two 16-bit truth-table maps with ones-counts and signals completion with a one-cycle done pulse.

---
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a 4-input logic stage through all 16 input
// vectors. Each vector is held for a programmable settle time, the returned
// F1/F2 are sampled, and two 16-bit truth-table maps with ones-counts are built.
// A one-cycle done pulse marks the results as valid.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        F1_in,
  input  logic        F2_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] f1_map,
  output logic [15:0] f2_map,
  output logic [4:0]  ones_f1,
  output logic [4:0]  ones_f2
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Wait-counter reload: SETTLE runs for wait values RELOAD down to 0.
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] index;
  logic [3:0] wait_cnt;

  // The stimulus is the index register itself, so it only changes at clock
  // edges and cannot glitch.
  assign {A, B, C, D} = index;

  // Sweep sequencer: state, index, settle timing, map capture and counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      index    <= 4'd0;
      wait_cnt <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      f1_map   <= 16'h0000;
      f2_map   <= 16'h0000;
      ones_f1  <= 5'd0;
      ones_f2  <= 5'd0;
    end else begin
      // done is high only for the single cycle spent in DONE.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SETTLE;
            index    <= 4'd0;
            wait_cnt <= RELOAD;
            busy     <= 1'b1;
            f1_map   <= 16'h0000;
            f2_map   <= 16'h0000;
            ones_f1  <= 5'd0;
            ones_f2  <= 5'd0;
          end
        end
        SETTLE: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          // Capture happens only here; F_in activity during SETTLE is ignored.
          f1_map[index] <= F1_in;
          f2_map[index] <= F2_in;
          // Counts track the maps incrementally; each index is written once
          // per sweep after a clear, so they always equal the map popcounts.
          ones_f1 <= ones_f1 + {4'd0, F1_in};
          ones_f2 <= ones_f2 + {4'd0, F2_in};
          if (index != 4'd15) begin
            index    <= index + 4'd1;
            wait_cnt <= RELOAD;
            state    <= SETTLE;
          end else begin
            // Last vector: index stays at 15 for the DONE cycle.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          index <= 4'd0;
        end
        default: begin
          state <= IDLE;
          index <= 4'd0;
        end
      endcase
    end
  end

endmodule
